// File: rtl/ram_block_mover_if.sv
// Bus bundle for ram_block_mover: control handshake plus the single-port RAM initiator signals.
// RAM_MOVER_FILL_EN adds the fill and fillValue signals for the constant-fill mode.
interface ram_block_mover_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic                  abort;
   logic [ADDR_WIDTH-1:0] src;
   logic [ADDR_WIDTH-1:0] dst;
   logic [ADDR_WIDTH-1:0] len;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] count;
   logic                  memLoad;
   logic [ADDR_WIDTH-1:0] memAddress;
   logic [DATA_WIDTH-1:0] memDataIn;
   logic [DATA_WIDTH-1:0] memDataOut;
`ifdef RAM_MOVER_FILL_EN
   logic                  fill;
   logic [DATA_WIDTH-1:0] fillValue;

   modport master (
      output start, abort, src, dst, len, fill, fillValue, memDataOut,
      input  busy, done, count, memLoad, memAddress, memDataIn
   );

   modport slave (
      input  start, abort, src, dst, len, fill, fillValue, memDataOut,
      output busy, done, count, memLoad, memAddress, memDataIn
   );
`else
   modport master (
      output start, abort, src, dst, len, memDataOut,
      input  busy, done, count, memLoad, memAddress, memDataIn
   );

   modport slave (
      input  start, abort, src, dst, len, memDataOut,
      output busy, done, count, memLoad, memAddress, memDataIn
   );
`endif
endinterface

// File: rtl/ram_block_mover.sv
// Memmove-safe block copier acting as a RAM bus initiator (2 cycles per word).
// Optional macro RAM_MOVER_FILL_EN adds a constant-fill mode (1 cycle per word).
module ram_block_mover #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input logic               i_clk,
   input logic               i_rst,
   ram_block_mover_if.slave  bus
);

`ifdef RAM_MOVER_FILL_EN
   typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WRITE, ST_FINISH, ST_FILL} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_FINISH} state_t;
`endif

   state_t                r_state;
   state_t                w_nextState;
   logic [ADDR_WIDTH-1:0] r_srcPtr;
   logic [ADDR_WIDTH-1:0] r_dstPtr;
   logic [ADDR_WIDTH-1:0] r_len;
   logic [ADDR_WIDTH-1:0] r_count;
   logic [DATA_WIDTH-1:0] r_buf;
   logic                  r_backward;
`ifdef RAM_MOVER_FILL_EN
   logic [DATA_WIDTH-1:0] r_fillValue;
`endif

   logic [ADDR_WIDTH-1:0] w_diff;
   logic [ADDR_WIDTH-1:0] w_lenMinus1;
   logic [ADDR_WIDTH-1:0] w_countInc;
   logic                  w_backward;
   logic                  w_goBack;
   logic                  w_lastWord;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_memLoad;
   logic [ADDR_WIDTH-1:0] w_memAddress;
   logic [DATA_WIDTH-1:0] w_memDataIn;

   // Copy backward only when the destination starts inside the source window (modular distance).
   assign w_diff      = bus.dst - bus.src;
   assign w_lenMinus1 = bus.len - ADDR_WIDTH'(1);
   assign w_backward  = (bus.dst != bus.src) && (w_diff < bus.len);
`ifdef RAM_MOVER_FILL_EN
   assign w_goBack    = w_backward && !bus.fill;
`else
   assign w_goBack    = w_backward;
`endif
   assign w_countInc  = r_count + ADDR_WIDTH'(1);
   assign w_lastWord  = (w_countInc == r_len);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.len == '0) begin
                  w_nextState = ST_FINISH;
`ifdef RAM_MOVER_FILL_EN
               end else if (bus.fill) begin
                  w_nextState = ST_FILL;
`endif
               end else begin
                  w_nextState = ST_READ;
               end
            end
         end
         ST_READ:   w_nextState = bus.abort ? ST_FINISH : ST_WRITE;
         ST_WRITE:  w_nextState = (bus.abort || w_lastWord) ? ST_FINISH : ST_READ;
`ifdef RAM_MOVER_FILL_EN
         ST_FILL:   w_nextState = (bus.abort || w_lastWord) ? ST_FINISH : ST_FILL;
`endif
         ST_FINISH: w_nextState = ST_IDLE;
         default:   w_nextState = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_memLoad    = 1'b0;
      w_memAddress = '0;
      w_memDataIn  = '0;
      case (r_state)
         ST_READ: begin
            w_busy       = 1'b1;
            w_memAddress = r_srcPtr;
         end
         ST_WRITE: begin
            w_busy       = 1'b1;
            w_memLoad    = 1'b1;
            w_memAddress = r_dstPtr;
            w_memDataIn  = r_buf;
         end
`ifdef RAM_MOVER_FILL_EN
         ST_FILL: begin
            w_busy       = 1'b1;
            w_memLoad    = 1'b1;
            w_memAddress = r_dstPtr;
            w_memDataIn  = r_fillValue;
         end
`endif
         ST_FINISH: w_done = 1'b1;
         default: ;
      endcase
   end

   // Operands are captured only in IDLE, so a START pulse mid-transfer cannot disturb them.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_srcPtr    <= '0;
         r_dstPtr    <= '0;
         r_len       <= '0;
         r_count     <= '0;
         r_buf       <= '0;
         r_backward  <= 1'b0;
`ifdef RAM_MOVER_FILL_EN
         r_fillValue <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_srcPtr    <= w_goBack ? (bus.src + w_lenMinus1) : bus.src;
                  r_dstPtr    <= w_goBack ? (bus.dst + w_lenMinus1) : bus.dst;
                  r_len       <= bus.len;
                  r_count     <= '0;
                  r_backward  <= w_goBack;
`ifdef RAM_MOVER_FILL_EN
                  r_fillValue <= bus.fillValue;
`endif
               end
            end
            ST_READ: r_buf <= bus.memDataOut;
            ST_WRITE: begin
               r_count  <= w_countInc;
               r_srcPtr <= r_backward ? (r_srcPtr - ADDR_WIDTH'(1)) : (r_srcPtr + ADDR_WIDTH'(1));
               r_dstPtr <= r_backward ? (r_dstPtr - ADDR_WIDTH'(1)) : (r_dstPtr + ADDR_WIDTH'(1));
            end
`ifdef RAM_MOVER_FILL_EN
            ST_FILL: begin
               r_count  <= w_countInc;
               r_dstPtr <= r_dstPtr + ADDR_WIDTH'(1);
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.count      = r_count;
   assign bus.memLoad    = w_memLoad;
   assign bus.memAddress = w_memAddress;
   assign bus.memDataIn  = w_memDataIn;

endmodule

// File: tb/tb_ram_block_mover.sv
// Self-checking bench for ram_block_mover: table vectors plus random transfers against a memmove model.
// Define RAM_MOVER_FILL_EN to also exercise the fill mode.
module tb_ram_block_mover;

   logic clk;
   logic rst;

   ram_block_mover_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   ram_block_mover #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] src;
      logic [15:0] dst;
      logic [15:0] len;
      int          abortEdge;
      int          glitchEdge;
      bit          startAbort;
      bit          fill;
      logic [15:0] fillVal;
      int          expCount;
      int          expEdges;
   } vec_t;

   logic [15:0] ram    [65536];
   logic [15:0] refMem [65536];
   logic [15:0] readQ[$];
   logic [15:0] writeQ[$];
   logic [15:0] expRead[$];
   logic [15:0] expWrite[$];
   vec_t        vecs[$];
   int          errors = 0;
   int          checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational-read, clocked-write RAM model
   assign bus.memDataOut = ram[bus.memAddress];
   always @(posedge clk) begin
      if (bus.memLoad) ram[bus.memAddress] <= bus.memDataIn;
   end

   always @(negedge clk) begin
      if (bus.memLoad) writeQ.push_back(bus.memAddress);
      else if (bus.busy) readQ.push_back(bus.memAddress);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: memmove semantics, direction chosen by modular distance, abort truncates the word list.
   task automatic buildExpect(input vec_t v, output int cnt, output int edges);
      int          nRead;
      int          idx;
      bit          back;
      logic [15:0] d;
      logic [15:0] a;
      logic [15:0] tmp[$];
      int          len;
      len = int'(v.len);
      expRead.delete();
      expWrite.delete();
      d    = v.dst - v.src;
      back = (v.dst != v.src) && (d < v.len);
      if (v.fill) begin
         if (v.abortEdge < 0 || v.abortEdge >= len) begin
            cnt = len; edges = len;
         end else begin
            cnt = v.abortEdge + 1; edges = v.abortEdge + 1;
         end
         for (int i = 0; i < cnt; i++) begin
            a = v.dst + 16'(i);
            expWrite.push_back(a);
            refMem[a] = v.fillVal;
         end
      end else begin
         if (v.abortEdge < 0 || v.abortEdge >= 2 * len) begin
            cnt = len; nRead = len; edges = 2 * len;
         end else begin
            nRead = v.abortEdge / 2 + 1;
            cnt   = (v.abortEdge % 2 == 1) ? nRead : nRead - 1;
            edges = v.abortEdge + 1;
         end
         for (int i = 0; i < len; i++) begin
            a = v.src + 16'(i);
            tmp.push_back(refMem[a]);
         end
         for (int i = 0; i < nRead; i++) begin
            idx = back ? (len - 1 - i) : i;
            expRead.push_back(v.src + 16'(idx));
         end
         for (int i = 0; i < cnt; i++) begin
            idx = back ? (len - 1 - i) : i;
            a = v.dst + 16'(idx);
            expWrite.push_back(a);
            refMem[a] = tmp[idx];
         end
      end
   endtask

   task automatic compareQueues(input string name, input logic [15:0] act[$], input logic [15:0] exp[$]);
      int bad;
      checkOutput({name, "Count"}, act.size(), exp.size());
      bad = -1;
      for (int i = 0; i < exp.size() && i < act.size(); i++) begin
         if (bad < 0 && act[i] !== exp[i]) bad = i;
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("[TB] FAIL %sAddr[%0d]: got %0h expected %0h", name, bad, act[bad], exp[bad]);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      int  n;
      int  expCnt;
      int  expEdges;
      int  budget;
      int  diffs;
      int  firstDiff;
      bit  finished;
      for (int a = 0; a < 65536; a++) refMem[a] = ram[a];
      buildExpect(v, expCnt, expEdges);
      if (v.expCount >= 0) begin
         expCnt   = v.expCount;
         expEdges = v.expEdges;
      end
      readQ.delete();
      writeQ.delete();
      @(negedge clk);
      bus.src   = v.src;
      bus.dst   = v.dst;
      bus.len   = v.len;
      bus.start = 1'b1;
      bus.abort = v.startAbort;
`ifdef RAM_MOVER_FILL_EN
      bus.fill      = v.fill;
      bus.fillValue = v.fillVal;
`endif
      @(posedge clk);
      n        = 0;
      budget   = 2 * int'(v.len) + 8;
      finished = 1'b0;
      while (!finished) begin
         @(negedge clk);
         if (bus.done) begin
            finished = 1'b1;
         end else if (n > budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout: got no DONE after %0d edges expected %0d", n, expEdges);
            finished = 1'b1;
         end else begin
            bus.start = (n == v.glitchEdge);
            if (n == v.glitchEdge) begin
               bus.src = ~v.src;
               bus.dst = ~v.dst;
               bus.len = v.len + 16'd3;
            end
            bus.abort = (n == v.abortEdge);
            @(posedge clk);
            n++;
         end
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      checkOutput("doneLatency", n, expEdges);
      checkOutput("countAtDone", bus.count, expCnt);
      @(negedge clk);
      checkOutput("donePulse", bus.done, 0);
      @(negedge clk);
      checkOutput("countHeld", bus.count, expCnt);
      checkOutput("busyIdle", bus.busy, 0);
      compareQueues("read", readQ, expRead);
      compareQueues("write", writeQ, expWrite);
      diffs = 0;
      firstDiff = -1;
      for (int a = 0; a < 65536; a++) begin
         if (ram[a] !== refMem[a]) begin
            diffs++;
            if (firstDiff < 0) firstDiff = a;
         end
      end
      checks++;
      if (diffs != 0) begin
         errors++;
         $display("[TB] FAIL memory: got %0d differing words (first at %0h) expected 0", diffs, firstDiff);
      end
   endtask

   initial begin
      vec_t v;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.src        = '0;
      bus.dst        = '0;
      bus.len        = '0;
`ifdef RAM_MOVER_FILL_EN
      bus.fill       = 1'b0;
      bus.fillValue  = '0;
`endif
      for (int a = 0; a < 65536; a++) ram[a] = 16'(a * 13 + 5) ^ 16'h5A00;
      for (int i = 0; i < 4; i++) ram[16'h100 + 16'(i)] = 16'(i + 1);
      for (int i = 0; i < 4; i++) ram[16'h010 + 16'(i)] = 16'hA + 16'(i);

      rst = 1'b1;
      #1;
      checkOutput("resetBusy", bus.busy, 0);
      checkOutput("resetDone", bus.done, 0);
      checkOutput("resetLoad", bus.memLoad, 0);
      checkOutput("resetCount", bus.count, 0);
      checkOutput("resetAddr", bus.memAddress, 0);
      checkOutput("resetDataIn", bus.memDataIn, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      //            src       dst       len    abort glitch stAb fill fillVal  cnt edges
      vecs.push_back('{16'h0100, 16'h0200, 16'd4, -1, -1, 1'b0, 1'b0, 16'h0, 4, 8});
      vecs.push_back('{16'h0010, 16'h0011, 16'd4, -1, -1, 1'b0, 1'b0, 16'h0, 4, 8});
      vecs.push_back('{16'h0050, 16'h0060, 16'd0, -1, -1, 1'b0, 1'b0, 16'h0, 0, 0});
      vecs.push_back('{16'hFFFE, 16'h0400, 16'd4, -1, -1, 1'b0, 1'b0, 16'h0, 4, 8});
      vecs.push_back('{16'h0500, 16'h0600, 16'd5,  3,  1, 1'b0, 1'b0, 16'h0, 2, 4});
      vecs.push_back('{16'h0520, 16'h0620, 16'd5,  2, -1, 1'b0, 1'b0, 16'h0, 1, 3});
      vecs.push_back('{16'h0540, 16'h0640, 16'd3, -1,  4, 1'b1, 1'b0, 16'h0, 3, 6});
      vecs.push_back('{16'h0700, 16'h0703, 16'd4, -1, -1, 1'b0, 1'b0, 16'h0, 4, 8});
      vecs.push_back('{16'h0800, 16'h0800, 16'd3, -1, -1, 1'b0, 1'b0, 16'h0, 3, 6});
      vecs.push_back('{16'h0900, 16'hFFFF, 16'd3, -1, -1, 1'b0, 1'b0, 16'h0, 3, 6});
      vecs.push_back('{16'h0A05, 16'h0A02, 16'd6, -1, -1, 1'b0, 1'b0, 16'h0, 6, 12});
`ifdef RAM_MOVER_FILL_EN
      vecs.push_back('{16'h0000, 16'h0300, 16'd3, -1, -1, 1'b0, 1'b1, 16'hA5A5, 3, 3});
      vecs.push_back('{16'h0000, 16'h0310, 16'd4,  1, -1, 1'b0, 1'b1, 16'h1234, 2, 2});
      vecs.push_back('{16'h0000, 16'h0320, 16'd0, -1, -1, 1'b0, 1'b1, 16'h7777, 0, 0});
      vecs.push_back('{16'hFFFF, 16'h0000, 16'd3, -1, -1, 1'b0, 1'b1, 16'h0F0F, 3, 3});
`endif
      foreach (vecs[i]) applyStimulus(vecs[i]);

      for (int r = 0; r < 24; r++) begin
         v.src        = 16'($urandom);
         v.dst        = v.src + 16'($urandom_range(0, 48)) - 16'd24;
         v.len        = 16'($urandom_range(0, 20));
         v.fill       = 1'b0;
`ifdef RAM_MOVER_FILL_EN
         v.fill       = ($urandom_range(0, 3) == 0);
`endif
         v.fillVal    = 16'($urandom);
         v.abortEdge  = -1;
         if (v.len != 0 && $urandom_range(0, 2) == 0)
            v.abortEdge = $urandom_range(0, (v.fill ? 1 : 2) * int'(v.len) - 1);
         v.glitchEdge = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2 * int'(v.len) + 1) : -1;
         v.startAbort = ($urandom_range(0, 4) == 0);
         v.expCount   = -1;
         v.expEdges   = -1;
         applyStimulus(v);
      end

      // ABORT while idle must not start or disturb anything
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("idleAbortBusy", bus.busy, 0);
      checkOutput("idleAbortDone", bus.done, 0);
      bus.abort = 1'b0;

      // Reset asserted mid-write drops LOAD asynchronously
      @(negedge clk);
      bus.src   = 16'h0100;
      bus.dst   = 16'h0B00;
      bus.len   = 16'd4;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #2;
      checkOutput("loadBeforeReset", bus.memLoad, 1);
      rst = 1'b1;
      #1;
      checkOutput("asyncResetLoad", bus.memLoad, 0);
      checkOutput("asyncResetBusy", bus.busy, 0);
      checkOutput("asyncResetCount", bus.count, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postResetBusy", bus.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
